// File: rtl/fp32_pkg.sv
// Shared fp32 field layout, special constants, pi/2 fixed-point source and
// the range-reduction FSM state encoding.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    // fp32 pi/2 rounds up, so any magnitude below this pattern is below true pi/2
    localparam logic [30:0] FP32_PIO2_MAG = 31'h3FC9_0FDB;

    // pi/2 * 2^60, rounded to nearest
    localparam logic [63:0] PIO2_Q60 = 64'h1921_FB54_442D_1847;

    function automatic logic [63:0] pio2_fixed(input int frac);
        logic [63:0] v;
        if (frac >= 60) begin
            v = PIO2_Q60 << (frac - 60);
        end else begin
            v = PIO2_Q60 >> (59 - frac);
            v = (v + 64'd1) >> 1;
        end
        return v;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        DIV,
        NORM,
        DONE
    } rr_state_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W = 56
) (
    input  logic [W-1:0]               a,
    output logic [$clog2(W+1)-1:0]     cnt
);

    localparam int CW = $clog2(W + 1);

    // Scanning upward, the last set bit seen is the leading one.
    always_comb begin
        cnt = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (a[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_range_reduce.sv
// Reduces an fp32 angle modulo pi/2 by bit-serial restoring division in
// fixed point, returning remainder, quadrant and sign.
module fp32_range_reduce
    import fp32_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] r,
    output logic [1:0]  quad,
    output logic        sgn,
    output logic        err
);

    localparam int W   = INT_BITS + FRAC_BITS;
    localparam int CW  = $clog2(W);
    localparam int LZW = $clog2(W + 1);
    localparam logic [W-1:0] PIO2 = W'(pio2_fixed(FRAC_BITS));

    rr_state_e        state_q, state_d;
    logic [30:0]      abs_q, abs_d;
    logic [W-1:0]     div_q, div_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       quad_q, quad_d;
    logic [31:0]      r_q, r_d;
    logic             sgn_q, sgn_d;
    logic             err_q, err_d;

    logic [EXP_W-1:0] exp_in;
    logic             is_err_in;
    logic             bypass_in;
    logic [W-1:0]     sig;
    logic [W-1:0]     fix;
    logic signed [15:0] sh;
    logic [W-1:0]     rem_sh;
    logic             ge;
    logic [LZW-1:0]   lz;
    logic signed [15:0] e_i;
    logic [W-1:0]     norm;
    logic [31:0]      r_norm;

    fp_lzc #(.W(W)) u_lzc (
        .a   (rem_q),
        .cnt (lz)
    );

    always_comb begin
        exp_in    = x[30:23];
        is_err_in = (exp_in == '1) || (int'(exp_in) >= EXP_BIAS + INT_BITS - 1);
        bypass_in = is_err_in || (exp_in == '0) || (x[30:0] < FP32_PIO2_MAG);

        // {1,mantissa} sits at weight 2^-23; move it to weight 2^-FRAC_BITS
        sig = W'({1'b1, abs_q[MANT_W-1:0]});
        sh  = $signed({8'd0, abs_q[30:23]}) + 16'(FRAC_BITS - MANT_W - EXP_BIAS);
        fix = (sh >= 16'sd0) ? (sig << sh) : (sig >> (-sh));

        rem_sh = {rem_q[W-2:0], div_q[W-1]};
        ge     = (rem_sh >= PIO2);

        e_i    = 16'(EXP_BIAS + W - 1 - FRAC_BITS) - 16'(lz);
        norm   = rem_q << (lz + LZW'(1));
        r_norm = ((rem_q == '0) || (e_i <= 16'sd0)) ? '0
               : {1'b0, e_i[EXP_W-1:0], norm[W-1 -: MANT_W]};
    end

    always_comb begin
        state_d = state_q;
        abs_d   = abs_q;
        div_d   = div_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quad_d  = quad_q;
        r_d     = r_q;
        sgn_d   = sgn_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_d  = x[31];
                    err_d  = is_err_in;
                    quad_d = '0;
                    abs_d  = x[30:0];
                    if (bypass_in) begin
                        state_d = DONE;
                        if (is_err_in) begin
                            r_d = FP32_QNAN;
                        end else if (exp_in == '0) begin
                            r_d = '0;
                        end else begin
                            r_d = {1'b0, x[30:0]};
                        end
                    end else begin
                        state_d = ALIGN;
                        r_d     = '0;
                    end
                end
            end
            ALIGN: begin
                div_d   = fix;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                div_d  = div_q << 1;
                rem_d  = ge ? (rem_sh - PIO2) : rem_sh;
                quad_d = {quad_q[0], ge};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                r_d     = r_norm;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            abs_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quad_q  <= '0;
            r_q     <= '0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            abs_q   <= abs_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quad_q  <= quad_d;
            r_q     <= r_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign r         = r_q;
    assign quad      = quad_q;
    assign sgn       = sgn_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fp32_range_reduce.sv
// Directed self-checking bench for fp32_range_reduce.
module tb_fp32_range_reduce;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic [1:0]  quad;
    logic        sgn;
    logic        err;

    int  n_checks = 0;
    int  n_pass   = 0;
    real pio2_r;

    typedef struct {
        logic [31:0] xv;
        int          n;
    } fp_vec_t;

    fp32_range_reduce #(.INT_BITS(16), .FRAC_BITS(40)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .quad      (quad),
        .sgn       (sgn),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic real fp32_to_real(input logic [31:0] b);
        int e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        return (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    endfunction

    function automatic real ulp_of(input real v);
        real p;
        p = 1.0;
        if (v <= 0.0) return 2.0 ** (-149);
        while (p > v) p = p / 2.0;
        while (p * 2.0 <= v) p = p * 2.0;
        return p / 8388608.0;
    endfunction

    task automatic send(input logic [31:0] xv, output int lat);
        @(negedge clk);
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = $urandom();
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_valid, r, quad, sgn, err} !== 37'd0)
            $display("FAIL reset_outputs: got %b/%h/%0d/%b/%b required all zero",
                     out_valid, r, quad, sgn, err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] xs[7];
        logic [31:0] rs[7];
        int lat;
        xs = '{32'h3100_0000, 32'h3F40_0000, 32'hBF40_0000, 32'h8000_0000,
               32'h0000_0000, 32'h0040_0000, 32'h3FC9_0FDA};
        rs = '{32'h3100_0000, 32'h3F40_0000, 32'h3F40_0000, 32'h0000_0000,
               32'h0000_0000, 32'h0000_0000, 32'h3FC9_0FDA};
        for (int i = 0; i < 7; i++) begin
            send(xs[i], lat);
            n_checks++;
            if (lat !== 1) $display("FAIL bypass_latency x=%h: got %0d required 1", xs[i], lat);
            else n_pass++;
            n_checks++;
            if (r !== rs[i]) $display("FAIL bypass_r x=%h: got %h required %h", xs[i], r, rs[i]);
            else n_pass++;
            n_checks++;
            if ({quad, err} !== 3'b000) $display("FAIL bypass_quad_err x=%h: got %0d/%b required 0/0", xs[i], quad, err);
            else n_pass++;
            n_checks++;
            if (sgn !== xs[i][31]) $display("FAIL bypass_sgn x=%h: got %b required %b", xs[i], sgn, xs[i][31]);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_err();
        logic [31:0] xs[5];
        int lat;
        xs = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h47C3_5000, 32'h4700_0000};
        for (int i = 0; i < 5; i++) begin
            send(xs[i], lat);
            n_checks++;
            if (lat !== 1) $display("FAIL err_latency x=%h: got %0d required 1", xs[i], lat);
            else n_pass++;
            n_checks++;
            if (r !== 32'h7FC0_0000 || err !== 1'b1 || quad !== 2'd0)
                $display("FAIL err_result x=%h: got r=%h err=%b quad=%0d required 7fc00000/1/0", xs[i], r, err, quad);
            else n_pass++;
            n_checks++;
            if (sgn !== xs[i][31]) $display("FAIL err_sgn x=%h: got %b required %b", xs[i], sgn, xs[i][31]);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_full_path();
        fp_vec_t fv[7];
        int lat;
        real er, rr;
        logic [1:0] eq;
        fv = '{'{32'hC000_0000, 1}, '{32'h42F0_0000, 76}, '{32'hC3E4_0000, 290},
               '{32'h40C9_0FDB, 4}, '{32'h4040_0000, 1}, '{32'h3FC9_0FDB, 1},
               '{32'h46FF_FE00, 20860}};
        for (int i = 0; i < 7; i++) begin
            send(fv[i].xv, lat);
            eq = 2'(fv[i].n % 4);
            er = fp32_to_real({1'b0, fv[i].xv[30:0]}) - real'(fv[i].n) * pio2_r;
            rr = fp32_to_real(r);
            n_checks++;
            if (lat !== 59) $display("FAIL full_latency x=%h: got %0d required 59", fv[i].xv, lat);
            else n_pass++;
            n_checks++;
            if (quad !== eq) $display("FAIL full_quad x=%h: got %0d required %0d", fv[i].xv, quad, eq);
            else n_pass++;
            n_checks++;
            if (sgn !== fv[i].xv[31] || err !== 1'b0)
                $display("FAIL full_sgn_err x=%h: got %b/%b required %b/0", fv[i].xv, sgn, err, fv[i].xv[31]);
            else n_pass++;
            n_checks++;
            if (r[31] !== 1'b0 || (rr - er > 2.0 * ulp_of(er)) || (er - rr > 2.0 * ulp_of(er)))
                $display("FAIL full_r x=%h: got %h (%g) required %g", fv[i].xv, r, rr, er);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [35:0] snap;
        logic stable;
        send(32'h4040_0000, lat);
        snap = {r, quad, sgn, err};
        n_checks++;
        if (lat !== 59 || quad !== 2'd1) $display("FAIL bp_result: got lat=%0d quad=%0d required 59/1", lat, quad);
        else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if ({out_valid, in_ready, r, quad, sgn, err} !== {2'b10, snap}) stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) $display("FAIL bp_stable: got %b required 1", stable);
        else n_pass++;
        consume();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        int lat;
        logic bad;
        real er, rr;
        @(negedge clk);
        x        = 32'hC3E4_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, r, quad, sgn, err} !== 37'd0)
            $display("FAIL rst_div_outputs: got %b/%h/%0d/%b/%b required all zero",
                     out_valid, r, quad, sgn, err);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL rst_div_quiet: got %b required 0", bad);
        else n_pass++;
        send(32'h4040_0000, lat);
        er = 3.0 - pio2_r;
        rr = fp32_to_real(r);
        n_checks++;
        if (lat !== 59 || quad !== 2'd1 || sgn !== 1'b0)
            $display("FAIL rst_div_next: got lat=%0d quad=%0d sgn=%b required 59/1/0", lat, quad, sgn);
        else n_pass++;
        n_checks++;
        if ((rr - er > 2.0 * ulp_of(er)) || (er - rr > 2.0 * ulp_of(er)))
            $display("FAIL rst_div_next_r: got %h (%g) required %g", r, rr, er);
        else n_pass++;
        consume();
    endtask

    task automatic test_busy_ignore();
        int lat;
        real er, rr;
        @(negedge clk);
        x        = 32'h42F0_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        x   = 32'h3F40_0000;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        er = 120.0 - 76.0 * pio2_r;
        rr = fp32_to_real(r);
        n_checks++;
        if (lat !== 59 || quad !== 2'd0)
            $display("FAIL busy_ignore: got lat=%0d quad=%0d required 59/0", lat, quad);
        else n_pass++;
        n_checks++;
        if ((rr - er > 2.0 * ulp_of(er)) || (er - rr > 2.0 * ulp_of(er)))
            $display("FAIL busy_ignore_r: got %h (%g) required %g", r, rr, er);
        else n_pass++;
        consume();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = 32'h3F40_0000;
        @(posedge clk);
        #1;
        x = 32'h3100_0000;
        n_checks++;
        if (out_valid !== 1'b1 || r !== 32'h3F40_0000)
            $display("FAIL b2b_first: got %b/%h required 1/3f400000", out_valid, r);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || r !== 32'h3100_0000)
            $display("FAIL b2b_second: got %b/%h required 1/31000000", out_valid, r);
        else n_pass++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        pio2_r    = real'(longint'(PI / 2.0 * (2.0 ** 40))) / (2.0 ** 40);
        test_reset();
        test_bypass();
        test_err();
        test_full_path();
        test_backpressure();
        test_reset_mid_div();
        test_busy_ignore();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
